// File: rtl/sumador_pkg.sv
// Shared definitions for the sign-magnitude adder.
//   SUM_W     : default operand width (sign + magnitude bits)
//   sign_idx  : bit index of the sign for a given operand width
//   sm_t      : sign/magnitude view of a default-width operand
//   sm_pack / sm_unpack : convert between sm_t fields and a flat operand
package sumador_pkg;

  localparam int unsigned SUM_W = 4;

  typedef struct packed {
    logic               s;
    logic [SUM_W-2:0]   m;
  } sm_t;

  // Sign lives in the MSB of a w-bit operand.
  function automatic int unsigned sign_idx(input int unsigned w);
    return w - 1;
  endfunction

  function automatic logic [SUM_W-1:0] sm_pack(input logic s, input logic [SUM_W-2:0] m);
    sm_t t;
    t.s = s;
    t.m = m;
    return t;
  endfunction

  function automatic sm_t sm_unpack(input logic [SUM_W-1:0] x);
    return sm_t'(x);
  endfunction

endpackage

// File: rtl/sm_mag_addsub.sv
// Combinational sign-magnitude add/subtract core (no zero normalization).
//   sa, ma : sign and zero-extended magnitude of operand A
//   sb, mb : sign and zero-extended magnitude of operand B
//   mag    : raw magnitude of the sum
//   sgn    : raw sign of the sum
module sm_mag_addsub #(
  parameter int unsigned W = 4
) (
  input  logic         sa,
  input  logic [W-1:0] ma,
  input  logic         sb,
  input  logic [W-1:0] mb,
  output logic [W-1:0] mag,
  output logic         sgn
);

  // Equal signs add; unequal signs subtract the smaller magnitude from the larger.
  always_comb begin
    mag = '0;
    sgn = 1'b0;
    if (sa == sb) begin
      mag = ma + mb;
      sgn = sa;
    end else if (ma > mb) begin
      mag = ma - mb;
      sgn = sa;
    end else if (mb > ma) begin
      mag = mb - ma;
      sgn = sb;
    end
  end

endmodule

// File: rtl/sumador_sg_mag.sv
// Registered sign-magnitude adder, one-cycle pipeline stage.
//   clk, rst        : clock, synchronous active-high reset
//   in_valid, a, b  : operand strobe and W-bit sign-magnitude operands
//   out_valid       : one-cycle strobe for a fresh result
//   res             : W-bit unsigned magnitude of the sum (extra carry bit)
//   sg              : sign of the sum, never set when res is zero
//   zero            : sum equals zero
module sumador_sg_mag
  import sumador_pkg::*;
#(
  parameter int unsigned W = SUM_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  output logic [W-1:0] res,
  output logic         sg,
  output logic         zero
);

  localparam int unsigned SI = sign_idx(W);

  logic [W-1:0] ma;
  logic [W-1:0] mb;
  logic [W-1:0] mag;
  logic         sgn;

  // Magnitudes are zero-extended so the sum keeps its carry bit.
  assign ma = W'(a[W-2:0]);
  assign mb = W'(b[W-2:0]);

  sm_mag_addsub #(.W(W)) u_core (
    .sa  (a[SI]),
    .ma  (ma),
    .sb  (b[SI]),
    .mb  (mb),
    .mag (mag),
    .sgn (sgn)
  );

  // Output registers; a zero result is always reported as positive zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      res       <= '0;
      sg        <= 1'b0;
      zero      <= 1'b1;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        res  <= mag;
        sg   <= sgn & (mag != '0);
        zero <= (mag == '0);
      end
    end
  end

endmodule

// File: tb/tb_sumador_sg_mag.sv
// Scoreboard bench for sumador_sg_mag: driver pushes expected results,
// monitor pops and compares whenever out_valid is seen.
module tb_sumador_sg_mag;
  import sumador_pkg::*;

  localparam int unsigned W = SUM_W;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic [W-1:0] res;
  logic         sg;
  logic         zero;

  typedef struct packed {
    logic [W-1:0] res;
    logic         sg;
    logic         zero;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         e;
  } vec_t;

  exp_t q[$];
  exp_t last;
  int   n_vec = 0;
  int   n_err = 0;

  sumador_sg_mag #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .res       (res),
    .sg        (sg),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  // Reference: convert to signed integers, add, split back into sign/magnitude.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int   vx, vy, s;
    vx = x[W-1] ? -int'(x[W-2:0]) : int'(x[W-2:0]);
    vy = y[W-1] ? -int'(y[W-2:0]) : int'(y[W-2:0]);
    s  = vx + vy;
    e.res  = W'(s < 0 ? -s : s);
    e.sg   = (s < 0);
    e.zero = (s == 0);
    return e;
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got res=%b sg=%b zero=%b, expected res=%b sg=%b zero=%b",
               name, act.res, act.sg, act.zero, exp.res, exp.sg, exp.zero);
    end
  endtask

  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic v, input exp_t e);
    @(negedge clk);
    a        = x;
    b        = y;
    in_valid = v;
    if (v && !rst) q.push_back(e);
  endtask

  // Monitor
  always @(posedge clk) begin
    exp_t cur;
    exp_t e;
    #1;
    cur = {res, sg, zero};
    if (rst) begin
      q.delete();
      e = {W'(0), 1'b0, 1'b1};
      check("reset_outputs", cur, e);
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_out_valid: got %b, expected 0", out_valid);
      end
      last = e;
    end else if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out_valid: got out_valid=1, expected 0 (no pending result)");
      end else begin
        e = q.pop_front();
        check("result", cur, e);
        last = e;
      end
    end else begin
      check("hold", cur, last);
    end
  end

  vec_t dir[13];

  initial begin
    dir[0]  = {4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1};
    dir[1]  = {4'b0100, 4'b0101, 4'b1001, 1'b0, 1'b0};
    dir[2]  = {4'b0100, 4'b0111, 4'b1011, 1'b0, 1'b0};
    dir[3]  = {4'b0100, 4'b1011, 4'b0001, 1'b0, 1'b0};
    dir[4]  = {4'b0011, 4'b1111, 4'b0100, 1'b1, 1'b0};
    dir[5]  = {4'b1100, 4'b1011, 4'b0111, 1'b1, 1'b0};
    dir[6]  = {4'b0011, 4'b1011, 4'b0000, 1'b0, 1'b1};
    dir[7]  = {4'b1000, 4'b1000, 4'b0000, 1'b0, 1'b1};
    dir[8]  = {4'b0111, 4'b0111, 4'b1110, 1'b0, 1'b0};
    dir[9]  = {4'b1111, 4'b1111, 4'b1110, 1'b1, 1'b0};
    dir[10] = {4'b1101, 4'b0010, 4'b0011, 1'b1, 1'b0};
    dir[11] = {4'b1000, 4'b0011, 4'b0011, 1'b0, 1'b0};
    dir[12] = {4'b0000, 4'b1010, 4'b0010, 1'b1, 1'b0};

    // Reset held with in_valid high: nothing may come out.
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 4'b0101;
    b        = 4'b0011;
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;

    // Directed vectors streamed back to back.
    foreach (dir[i]) drive(dir[i].a, dir[i].b, 1'b1, dir[i].e);

    // Valid drop with garbage operands: outputs must hold.
    drive(4'b0110, 4'b0101, 1'b1, {4'b1011, 1'b0, 1'b0});
    drive(4'b1111, 4'b0001, 1'b0, '0);
    drive(4'b1001, 4'b1001, 1'b0, '0);
    drive(4'b1010, 4'b0001, 1'b1, {4'b0001, 1'b1, 1'b0});

    // Reset mid-stream: operand sampled under reset is discarded,
    // first valid after reset comes out one cycle later.
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 4'b0111;
    b        = 4'b0111;
    @(negedge clk);
    rst      = 1'b0;
    a        = 4'b1100;
    b        = 4'b0001;
    q.push_back({4'b0011, 1'b1, 1'b0});

    // Exhaustive sweep against the reference model.
    for (int i = 0; i < 256; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      drive(iv[7:4], iv[3:0], 1'b1, model(iv[7:4], iv[3:0]));
    end

    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 10 && q.size() != 0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending results, expected 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
